// File: rtl/frodo_dec_if.sv
// Handshake bundle for frodo_dec_unit: start/c_in command, (a,s) pair stream
// with valid/ready, and the decoded result with valid/ready plus busy.
interface frodo_dec_if #(
  parameter int B = 2
);
  logic          start;
  logic [15:0]   c_in;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_s;
  logic          out_valid;
  logic          out_ready;
  logic [B-1:0]  out_m;
  logic [15:0]   out_raw;
  logic          busy;

  modport master (
    output start, c_in, in_valid, in_a, in_s, out_ready,
    input  in_ready, out_valid, out_m, out_raw, busy
  );

  modport slave (
    input  start, c_in, in_valid, in_a, in_s, out_ready,
    output in_ready, out_valid, out_m, out_raw, busy
  );
endinterface

// File: rtl/frodo_dec_unit.sv
// Frodo decrypt coefficient unit: m = decode(c - sum(b'_k*s_k) mod 2^LOGQ).
// Ports: clk, rstn (async low), io (frodo_dec_if.slave); FRODO_DEC_RAW_EN exposes diff on out_raw.
module frodo_dec_unit #(
  parameter int N    = 640,
  parameter int LOGQ = 15,
  parameter int B    = 2
) (
  input  logic         clk,
  input  logic         rstn,
  frodo_dec_if.slave   io
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [LOGQ:0] HALF =
    {{LOGQ{1'b0}}, 1'b1} << (LOGQ - B - 1);

  typedef enum logic [2:0] {
    IDLE, ACC, DRAIN, FINAL, OUT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [15:0]     prod_q;
  logic            prod_vld;
  logic [15:0]     acc_q;
  logic [LOGQ-1:0] c_q;
  logic [B-1:0]    m_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [15:0]     s_ext;
  logic [15:0]     prod_d;
  logic            fire;
  logic [LOGQ-1:0] diff;
  logic [LOGQ:0]   rnd;
  logic [B-1:0]    m_d;

  // Low 16 bits of an unsigned product equal the signed product's.
  assign s_ext  = {{11{io.in_s[4]}}, io.in_s[4:0]};
  assign prod_d = 16'(io.in_a * s_ext);
  assign fire   = io.in_valid & in_ready_q;

  // One extra bit so a rounding carry out of the top falls off.
  assign diff = c_q - acc_q[LOGQ-1:0];
  assign rnd  = {1'b0, diff} + HALF;
  assign m_d  = rnd[LOGQ-1 -: B];

`ifdef FRODO_DEC_RAW_EN
  logic [15:0] raw_q;
  assign io.out_raw = raw_q;
`else
  assign io.out_raw = 16'd0;
`endif

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_m     = m_q;
  assign io.busy      = busy_q;

  logic unused_ok;
  assign unused_ok = ^{acc_q, io.in_s, io.c_in};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      prod_q      <= '0;
      prod_vld    <= 1'b0;
      acc_q       <= '0;
      c_q         <= '0;
      m_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FRODO_DEC_RAW_EN
      raw_q       <= '0;
`endif
    end else begin
      prod_vld <= fire;
      if (fire) prod_q <= prod_d;
      if (prod_vld) acc_q <= acc_q + prod_q;
      unique case (state)
        IDLE: begin
          if (io.start) begin
            c_q        <= io.c_in[LOGQ-1:0];
            acc_q      <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ACC;
          end
        end
        ACC: begin
          if (fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              in_ready_q <= 1'b0;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: state <= FINAL;
        FINAL: begin
          m_q         <= m_d;
`ifdef FRODO_DEC_RAW_EN
          raw_q       <= 16'(diff);
`endif
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/frodo_dec_unit.md
# frodo_dec_unit

Decryption-side arithmetic unit for the Frodo datapath. For one output coefficient it streams N pairs (b'_k, s_k), accumulates the dot product sum(b'_k * s_k) mod 2^LOGQ, subtracts it from the ciphertext coefficient c, and decodes the difference to a B-bit message symbol. It consumes the product/sum format produced on the encryption side (a*b + c, mod 2^16, b a small signed sample) and inverts the Frodo encoding. It sits between the matrix-row fetch logic and the message/shared-secret assembly.

## Interface
- N, 640: dot-product length (number of pairs per coefficient), 1..4096.
- LOGQ, 15: modulus exponent; arithmetic is mod 2^LOGQ, 2 <= LOGQ <= 16.
- B, 2: decoded bits per coefficient, 1 <= B < LOGQ.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  begin a coefficient; sampled only in IDLE.
- c_in  in  16  ciphertext coefficient; captured when start is accepted; bits above LOGQ ignored.
- in_valid  in  1  pair valid.
- in_ready  out  1  unit accepts a pair this cycle.
- in_a  in  16  b'_k, unsigned.
- in_s  in  16  s_k; only in_s[4:0] used, as two's-complement -16..15.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_m  out  B  decoded symbol.
- out_raw  out  16  c - sum mod 2^LOGQ, zero-extended (see Configuration).
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACC, DRAIN, FINAL, OUT.
- IDLE: start=1 captures c_in, clears accumulator and pair counter, -> ACC. start in any other state ignored.
- ACC: in_ready=1. On in_valid&in_ready: register prod = in_a * sext(in_s[4:0]) (low 16 bits), increment counter. Next cycle the registered product is added to the accumulator (16-bit, wraps). After the N-th accept: in_ready drops the following cycle, -> DRAIN.
- DRAIN: one cycle; last product enters accumulator. -> FINAL.
- FINAL: diff = (c - acc) mod 2^LOGQ; m = ((diff + 2^(LOGQ-B-1)) >> (LOGQ-B)) mod 2^B, computed in LOGQ+1 bits so the rounding carry wraps to 0. Register out_m/out_raw, -> OUT.
- OUT: out_valid=1, out_m/out_raw held stable until out_ready=1; on handshake -> IDLE. A start in the same handshake cycle is ignored (start accepted only from IDLE).
- in_valid outside ACC is ignored; no pair is consumed.
- Bubbles (in_valid=0 in ACC) stall the counter; no limit on bubble count.
- Reset mid-operation: returns to IDLE, partial accumulation discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_m=0, out_raw=0, busy=0, state IDLE.
- start at cycle t -> in_ready=1 from t+1.
- Last pair accepted at cycle t -> in_ready=0 at t+1, out_valid=1 at t+3.
- Back-to-back pairs: 1 pair/cycle. Minimum coefficient time with no stalls: 1 (start) + N + 3 + 1 (out handshake) cycles.
- out_valid falls the cycle after out_ready handshake; busy falls in the same cycle.

## Configuration
- FRODO_DEC_RAW_EN defined: out_raw carries diff zero-extended to 16 bits, for the FO re-encryption compare path.
- Not defined: out_raw tied to 16'd0, diff register is LOGQ-B wider-bits-trimmed (only bits used by decode kept); out_m behaviour identical.

## Test plan
- N=4, LOGQ=15, B=2: c=0x4000, a={1,2,3,4}, s={1,1,1,1} -> out_m=2, out_raw=0x3FF6, out_valid 3 cycles after 4th accept.
- N=1: c=0, a=0x0001, s=0x001F (-1) -> acc=0x7FFF mod 2^15, out_raw=0x0001, out_m=0.
- N=4: a={0x2000 x4}, s={1,1,1,1}, c=0 -> accumulator wraps, out_raw=0x0000, out_m=0; c=0x6000 with a all 0 -> out_m=3; c=0x7800 -> rounding wraps, out_m=0.
- N=4, in_valid toggled 1,0,0,1,... and out_ready held 0 for 5 cycles -> same result as unstalled run, out_m/out_raw stable while out_valid=1, start pulses during busy ignored.
- rstn asserted after 2 of 4 pairs -> all outputs 0 immediately; new start with fresh data gives correct result with no residue.
- Build without FRODO_DEC_RAW_EN: vector 1 -> out_m=2, out_raw=0.
